stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions the raw buttons/switches and sequences RUN, PAUSED
// and ADJUST, producing count ticks, counter clear and display blink.
module stopwatch_ctrl #(
    parameter int unsigned DIV_1HZ   = 100000000,
    parameter int unsigned DIV_2HZ   = 50000000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic       clk_sel,
    input  logic       rst,
    input  logic       btn_pause_raw,
    input  logic       btn_clr_raw,
    input  logic       sw_adj_raw,
    input  logic       sw_sel_raw,
    output logic       tick,
    output logic       clr,
    output logic       adj,
    output logic       sel,
    output logic       paused,
    output logic       blink,
    output logic [1:0] state
);

    localparam int unsigned N_IN  = 4;
    localparam int unsigned DIV_W = 32;
    localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSED = 2'b01,
        ST_ADJUST = 2'b10
    } state_e;

    logic [N_IN-1:0]           raw;
    logic [N_IN-1:0]           sync1_q, sync1_d;
    logic [N_IN-1:0]           sync2_q, sync2_d;
    logic [N_IN-1:0]           db_q, db_d;
    logic [N_IN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic                      pause_prev_q, pause_prev_d;
    logic                      clr_prev_q, clr_prev_d;
    logic                      pause_evt_q, pause_evt_d;
    logic                      clr_q, clr_d;
    state_e                    state_q, state_d;
    logic                      ret_q, ret_d;
    logic [DIV_W-1:0]          div1_q, div1_d;
    logic [DIV_W-1:0]          div2_q, div2_d;
    logic                      tick_q, tick_d;
    logic                      blink_q, blink_d;
    logic                      adj_q, adj_d;
    logic                      paused_q, paused_d;
    logic                      run_stay, adj_stay, adj_entry, wrap1, wrap2;

    // Bit order shared by synchronizer, debounce and counter vectors.
    assign raw = {sw_sel_raw, sw_adj_raw, btn_clr_raw, btn_pause_raw};

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = '0;
        // A level flips only after DB_CYCLES consecutive disagreeing cycles.
        for (int i = 0; i < int'(N_IN); i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end

        pause_prev_d = db_q[0];
        pause_evt_d  = db_q[0] & ~pause_prev_q;
        clr_prev_d   = db_q[1];
        clr_d        = db_q[1] & ~clr_prev_q;

        // ret: 0 returns to RUN, 1 returns to PAUSED; adj outranks pause.
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            ST_RUN: begin
                if (db_q[2]) begin
                    state_d = ST_ADJUST;
                    ret_d   = 1'b0;
                end else if (pause_evt_q) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (db_q[2]) begin
                    state_d = ST_ADJUST;
                    ret_d   = 1'b1;
                end else if (pause_evt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!db_q[2]) begin
                    state_d = ret_q ? ST_PAUSED : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Dividers advance only while staying in their state, so no tick lands
        // on the first cycle of a different state.
        run_stay  = (state_q == ST_RUN) && (state_d == ST_RUN);
        adj_stay  = (state_q == ST_ADJUST) && (state_d == ST_ADJUST);
        adj_entry = (state_q != ST_ADJUST) && (state_d == ST_ADJUST);
        wrap1     = run_stay && (div1_q == DIV_W'(DIV_1HZ - 1));
        wrap2     = adj_stay && (div2_q == DIV_W'(DIV_2HZ - 1));

        div1_d = div1_q;
        if (run_stay) begin
            div1_d = wrap1 ? '0 : div1_q + DIV_W'(1);
        end
        div2_d = div2_q;
        if (adj_entry) begin
            div2_d = '0;
        end else if (adj_stay) begin
            div2_d = wrap2 ? '0 : div2_q + DIV_W'(1);
        end
        if (clr_d) begin
            div1_d = '0;
            div2_d = '0;
        end
        tick_d = (wrap1 || wrap2) && !clr_d;

        blink_d = blink_q;
        if ((state_d != ST_ADJUST) || adj_entry) begin
            blink_d = 1'b1;
        end else if (wrap2 && !clr_d) begin
            blink_d = ~blink_q;
        end

        adj_d    = (state_d == ST_ADJUST);
        paused_d = (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk_sel or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            db_cnt_q     <= '0;
            pause_prev_q <= 1'b0;
            clr_prev_q   <= 1'b0;
            pause_evt_q  <= 1'b0;
            clr_q        <= 1'b0;
            state_q      <= ST_RUN;
            ret_q        <= 1'b0;
            div1_q       <= '0;
            div2_q       <= '0;
            tick_q       <= 1'b0;
            blink_q      <= 1'b1;
            adj_q        <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            db_cnt_q     <= db_cnt_d;
            pause_prev_q <= pause_prev_d;
            clr_prev_q   <= clr_prev_d;
            pause_evt_q  <= pause_evt_d;
            clr_q        <= clr_d;
            state_q      <= state_d;
            ret_q        <= ret_d;
            div1_q       <= div1_d;
            div2_q       <= div2_d;
            tick_q       <= tick_d;
            blink_q      <= blink_d;
            adj_q        <= adj_d;
            paused_q     <= paused_d;
        end
    end

    assign tick   = tick_q;
    assign clr    = clr_q;
    assign adj    = adj_q;
    assign sel    = db_q[3];
    assign paused = paused_q;
    assign blink  = blink_q;
    assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: expected tick cycles queued ahead of time and matched
// as ticks appear; control outputs checked at fixed cycle points.
module tb_stopwatch_ctrl;

    localparam int unsigned DIV_1HZ   = 8;
    localparam int unsigned DIV_2HZ   = 4;
    localparam int unsigned DB_CYCLES = 3;

    logic       clk_sel = 1'b0;
    logic       rst = 1'b0;
    logic       btn_pause_raw = 1'b0;
    logic       btn_clr_raw = 1'b0;
    logic       sw_adj_raw = 1'b0;
    logic       sw_sel_raw = 1'b0;
    logic       tick, clr, adj, sel, paused, blink;
    logic [1:0] state;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    stopwatch_ctrl #(
        .DIV_1HZ  (DIV_1HZ),
        .DIV_2HZ  (DIV_2HZ),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk_sel      (clk_sel),
        .rst          (rst),
        .btn_pause_raw(btn_pause_raw),
        .btn_clr_raw  (btn_clr_raw),
        .sw_adj_raw   (sw_adj_raw),
        .sw_sel_raw   (sw_sel_raw),
        .tick         (tick),
        .clr          (clr),
        .adj          (adj),
        .sel          (sel),
        .paused       (paused),
        .blink        (blink),
        .state        (state)
    );

    always #5 clk_sel = ~clk_sel;
    always @(posedge clk_sel) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clr", 32'(clr), 32'd0);
        chk("rst_adj", 32'(adj), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        chk("rst_blink", 32'(blink), 32'd1);
    endtask

    // Advance to just after the posedge that makes cyc == c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_sel);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        goto(c);
        @(negedge clk_sel);
    endtask

    task automatic push_ticks(input int first, input int last, input int step);
        for (int t = first; t <= last; t += step) exp_q.push_back(t);
    endtask

    // Tick scoreboard: every tick must match the oldest expected cycle.
    initial forever begin
        @(negedge clk_sel);
        if (!rst && tick) begin
            if (exp_q.size() == 0) chk("tick_unexpected", 32'(tick), 32'd0);
            else chk("tick_cycle", cyc, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, ca, cb, cc, cp, cd, ce, cg, cr, c1, cf, held, tr;
        #1 rst = 1'b1;
        goto(3);
        chk_reset_outputs();
        rst = 1'b0;
        c0 = cyc;

        // Idle RUN: tick every 8 cycles.
        ca = c0 + 28;
        push_ticks(c0 + 8, ca + 6, int'(DIV_1HZ));
        at_neg(c0 + 10);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_blink", 32'(blink), 32'd1);

        // Pause press: PAUSED exactly 7 cycles after the raw press.
        goto(ca);
        btn_pause_raw = 1'b1;
        at_neg(ca + 6);
        chk("pause_lat_early", 32'(paused), 32'd0);
        at_neg(ca + 7);
        chk("pause_paused", 32'(paused), 32'd1);
        chk("pause_state", 32'(state), 32'd1);
        goto(ca + 10);
        btn_pause_raw = 1'b0;
        cb = ca + 47;
        at_neg(cb - 2);
        chk("pause_no_tick", exp_q.size(), 32'd0);
        chk("pause_hold_state", 32'(state), 32'd1);

        // Resume: tick phase continues from the held divider value.
        cc = cb + 20;
        cp = cc + 24;
        held = (ca + 6 - c0) % int'(DIV_1HZ);
        tr = cb + 7 + int'(DIV_1HZ) - held;
        goto(cb);
        push_ticks(tr, cp + 6, int'(DIV_1HZ));
        btn_pause_raw = 1'b1;
        at_neg(cb + 6);
        chk("resume_early", 32'(state), 32'd1);
        at_neg(cb + 7);
        chk("resume_state", 32'(state), 32'd0);
        goto(cb + 10);
        btn_pause_raw = 1'b0;

        // Two-cycle glitches never get through the debouncer.
        for (int i = 0; i < 4; i++) begin
            goto(cc + 4 * i);
            btn_pause_raw = 1'b1;
            goto(cc + 4 * i + 2);
            btn_pause_raw = 1'b0;
        end
        at_neg(cc + 20);
        chk("glitch_state", 32'(state), 32'd0);
        chk("glitch_paused", 32'(paused), 32'd0);

        // PAUSED -> ADJUST (seconds field) -> back to PAUSED.
        goto(cp);
        btn_pause_raw = 1'b1;
        at_neg(cp + 7);
        chk("pause2_state", 32'(state), 32'd1);
        goto(cp + 10);
        btn_pause_raw = 1'b0;
        cd = cp + 20;
        ce = cd + 32;
        goto(cd);
        push_ticks(cd + 10, ce + 5, int'(DIV_2HZ));
        sw_adj_raw = 1'b1;
        sw_sel_raw = 1'b1;
        at_neg(cd + 5);
        chk("adj_early", 32'(state), 32'd1);
        at_neg(cd + 6);
        chk("adj_state", 32'(state), 32'd2);
        chk("adj_adj", 32'(adj), 32'd1);
        chk("adj_sel", 32'(sel), 32'd1);
        chk("adj_paused", 32'(paused), 32'd0);
        chk("adj_blink_entry", 32'(blink), 32'd1);
        at_neg(cd + 10);
        chk("adj_blink_t1", 32'(blink), 32'd0);
        at_neg(cd + 14);
        chk("adj_blink_t2", 32'(blink), 32'd1);
        goto(cd + 16);
        btn_pause_raw = 1'b1;
        goto(cd + 22);
        btn_pause_raw = 1'b0;
        at_neg(cd + 30);
        chk("adj_pause_ignored", 32'(state), 32'd2);
        goto(ce);
        sw_adj_raw = 1'b0;
        at_neg(ce + 5);
        chk("adj_exit_early", 32'(state), 32'd2);
        chk("adj_blink_last", 32'(blink), 32'd0);
        at_neg(ce + 6);
        chk("ret_state", 32'(state), 32'd1);
        chk("ret_paused", 32'(paused), 32'd1);
        chk("ret_adj", 32'(adj), 32'd0);
        chk("ret_blink", 32'(blink), 32'd1);
        chk("ret_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset in ADJUST with both dividers mid-count.
        cg = ce + 10;
        goto(cg);
        push_ticks(cg + 10, cg + 12, int'(DIV_2HZ));
        sw_adj_raw = 1'b1;
        at_neg(cg + 10);
        chk("adj2_state", 32'(state), 32'd2);
        chk("adj2_blink", 32'(blink), 32'd0);
        goto(cg + 12);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs();
        chk("rst_q_empty", exp_q.size(), 32'd0);
        goto(cg + 15);
        rst = 1'b0;
        cr = cyc;
        push_ticks(cr + 10, cr + 14, int'(DIV_2HZ));
        at_neg(cr + 5);
        chk("readj_early", 32'(state), 32'd0);
        at_neg(cr + 6);
        chk("readj_state", 32'(state), 32'd2);
        chk("readj_adj", 32'(adj), 32'd1);
        chk("readj_sel", 32'(sel), 32'd1);
        chk("readj_blink", 32'(blink), 32'd1);
        goto(cr + 16);
        rst = 1'b1;
        sw_adj_raw = 1'b0;
        sw_sel_raw = 1'b0;
        chk("readj_q_empty", exp_q.size(), 32'd0);

        // Clear landing on a due tick suppresses it; next tick 8 cycles later.
        goto(cr + 19);
        rst = 1'b0;
        c1 = cyc;
        cf = c1 + 18;
        push_ticks(c1 + 8, c1 + 16, int'(DIV_1HZ));
        push_ticks(c1 + 32, c1 + 40, int'(DIV_1HZ));
        goto(cf);
        btn_clr_raw = 1'b1;
        at_neg(cf + 5);
        chk("clr_early", 32'(clr), 32'd0);
        at_neg(c1 + 24);
        chk("clr_pulse", 32'(clr), 32'd1);
        chk("clr_tick_supp", 32'(tick), 32'd0);
        chk("clr_state", 32'(state), 32'd0);
        at_neg(c1 + 25);
        chk("clr_one_cycle", 32'(clr), 32'd0);
        goto(cf + 10);
        btn_clr_raw = 1'b0;
        at_neg(c1 + 44);
        chk("clr_release", 32'(clr), 32'd0);
        chk("final_q_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
